// File: rtl/rv32i_fetch_ctrl.sv
// rtl/rv32i_fetch_ctrl.sv - instruction-fetch sequencer with one-entry skid buffer and redirect flush
module rv32i_fetch_ctrl #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic [WIDTH-1:0] i_imem_inst,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_inst
);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_inst_q, out_inst_d;

    logic             blocked;
    logic [WIDTH-1:0] redirect_target;

    assign blocked         = out_valid_q & ~i_ready;
    assign redirect_target = i_redirect_pc & ~WIDTH'(3);

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        skid_valid_d     = skid_valid_q;
        skid_pc_d        = skid_pc_q;
        skid_inst_d      = skid_inst_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_inst_d       = out_inst_q;

        if (i_redirect) begin
            // Whatever the memory returns this edge belongs to the wrong path.
            fetch_pc_d       = redirect_target;
            inflight_valid_d = 1'b0;
            skid_valid_d     = 1'b0;
            out_valid_d      = 1'b0;
            out_inst_d       = NOP_INST;
        end else if (blocked) begin
            // No issue while blocked, so at most the single in-flight word needs parking.
            inflight_valid_d = 1'b0;
            if (inflight_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = inflight_pc_q;
                skid_inst_d  = i_imem_inst;
            end
        end else begin
            inflight_valid_d = 1'b1;
            inflight_pc_d    = fetch_pc_q;
            fetch_pc_d       = fetch_pc_q + WIDTH'(4);
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = 1'b0;
            end else if (inflight_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = inflight_pc_q;
                out_inst_d  = i_imem_inst;
            end else begin
                out_valid_d = 1'b0;
                out_inst_d  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            skid_valid_q     <= 1'b0;
            skid_pc_q        <= RESET_PC;
            skid_inst_q      <= NOP_INST;
            out_valid_q      <= 1'b0;
            out_pc_q         <= RESET_PC;
            out_inst_q       <= NOP_INST;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            skid_valid_q     <= skid_valid_d;
            skid_pc_q        <= skid_pc_d;
            skid_inst_q      <= skid_inst_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_inst_q       <= out_inst_d;
        end
    end

    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = out_valid_q;
    assign o_pc        = out_pc_q;
    assign o_inst      = out_inst_q;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// tb/tb_rv32i_fetch_ctrl.sv - directed bench for rv32i_fetch_ctrl
module tb_rv32i_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_inst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;

    int checks   = 0;
    int failures = 0;

    rv32i_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_addr   (o_imem_addr),
        .i_imem_inst   (i_imem_inst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_inst        (o_inst)
    );

    always #5 clk = ~clk;

    // Memory word at address n is 0x1000_0000 + n, one-cycle synchronous read.
    initial i_imem_inst = 32'h0;
    always @(posedge clk) i_imem_inst <= 32'h1000_0000 + o_imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
        check({tag, "_pc"}, o_pc, pc);
        check({tag, "_inst"}, o_inst, 32'h1000_0000 + pc);
    endtask

    initial begin
        rst           = 1'b0;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        #12;
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_inst", o_inst, 32'h13);
        check("rst_pc", o_pc, 32'h0);
        check("rst_addr", o_imem_addr, 32'h0);

        // Reset release and steady streaming.
        @(negedge clk);
        rst = 1'b1;
        step();
        check("boot1_valid", {31'b0, o_valid}, 32'd0);
        check("boot1_addr", o_imem_addr, 32'h4);
        step();
        expect_out("s0", 32'h0);
        step();
        expect_out("s4", 32'h4);
        step();
        expect_out("s8", 32'h8);

        // Three-cycle stall with o_pc = 8.
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall", 32'h8);
            check("stall_addr", o_imem_addr, 32'h10);
        end
        i_ready = 1'b1;
        step();
        expect_out("rel12", 32'hC);
        step();
        expect_out("rel16", 32'h10);

        // Redirect to unaligned target while streaming.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0043;
        step();
        i_redirect = 1'b0;
        check("rd1_valid", {31'b0, o_valid}, 32'd0);
        check("rd1_inst", o_inst, 32'h13);
        check("rd1_addr", o_imem_addr, 32'h40);
        step();
        check("rd2_valid", {31'b0, o_valid}, 32'd0);
        check("rd2_addr", o_imem_addr, 32'h44);
        step();
        expect_out("rd40", 32'h40);
        step();
        expect_out("rd44", 32'h44);

        // Fill the skid, then redirect while still stalled.
        i_ready = 1'b0;
        step();
        expect_out("skid_hold", 32'h44);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        step();
        i_redirect = 1'b0;
        i_ready    = 1'b1;
        check("rs1_valid", {31'b0, o_valid}, 32'd0);
        step();
        check("rs2_valid", {31'b0, o_valid}, 32'd0);
        step();
        expect_out("rs200", 32'h200);
        step();
        expect_out("rs204", 32'h204);

        // Address wrap at the top of the space.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        step();
        i_redirect = 1'b0;
        step();
        step();
        expect_out("wrapF8", 32'hFFFF_FFF8);
        step();
        expect_out("wrapFC", 32'hFFFF_FFFC);
        step();
        expect_out("wrap0", 32'h0);

        // Asynchronous reset asserted between edges during a stall.
        i_ready = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, o_valid}, 32'd0);
        check("arst_inst", o_inst, 32'h13);
        check("arst_addr", o_imem_addr, 32'h0);
        check("arst_pc", o_pc, 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        i_ready = 1'b1;
        step();
        check("reboot_valid", {31'b0, o_valid}, 32'd0);
        step();
        expect_out("reboot0", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_fetch_ctrl.md
Name: rv32i_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipeline front end; owns the fetch PC and drives the address port of rv32i_inst_mem, which has a synchronous read with 1-cycle latency.
- Presents fetched instructions to decode through a valid/ready handshake.
- Absorbs decode stalls with a one-entry skid buffer.
- Handles branch/jump redirects by killing in-flight fetches.

Parameters:
- WIDTH, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, value driven on o_inst when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; all state clears immediately while low.
- o_imem_addr  out  WIDTH  fetch address to instruction memory; equals the fetch_pc register (no combinational path from inputs).
- i_imem_inst  in  WIDTH  memory read data; holds the word addressed at the previous rising edge.
- i_redirect  in  1  branch/jump taken; one-cycle pulse.
- i_redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- i_ready  in  1  decode accepts o_inst this cycle.
- o_valid  out  1  o_inst/o_pc hold a valid instruction.
- o_pc  out  WIDTH  PC of o_inst.
- o_inst  out  WIDTH  fetched instruction.

Behaviour:
- State:
  - fetch_pc
  - inflight_valid/inflight_pc: the memory sampled an address at the last edge.
  - skid_valid/skid_pc/skid_inst
  - output register: o_valid/o_pc/o_inst
- Reset (rst low, async):
  - fetch_pc = RESET_PC.
  - inflight_valid = skid_valid = o_valid = 0.
  - o_pc = RESET_PC, o_inst = NOP_INST.
- Definitions:
  - blocked = o_valid & ~i_ready.
  - issue = ~blocked & ~i_redirect.
- On an issue edge:
  - inflight_valid <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - The +4 is modulo 2^WIDTH: 32'hFFFF_FFFC wraps to 0.
- On a non-issue edge with no redirect: inflight_valid <= 0 and fetch_pc holds.
- Output advance (edge with ~blocked, no redirect), loaded in priority order:
  - skid_valid: output <= skid, skid_valid <= 0.
  - else inflight_valid: output <= {1, inflight_pc, i_imem_inst}.
  - else: o_valid <= 0 and o_inst <= NOP_INST; o_pc holds.
- Blocked edge (no redirect):
  - Output holds.
  - If inflight_valid, skid <= {inflight_pc, i_imem_inst} and skid_valid <= 1.
  - Because issue is 0 while blocked, the skid never overflows and at most one instruction is ever parked.
- Redirect edge (highest priority, overrides blocked):
  - fetch_pc <= {i_redirect_pc[WIDTH-1:2], 2'b00}.
  - inflight_valid <= 0, skid_valid <= 0, o_valid <= 0, o_inst <= NOP_INST.
  - The memory sample taken at this edge is discarded.
- Timing:
  - Redirect at edge E: target on o_imem_addr after E; issued at E+1; o_valid=1, o_pc=target after E+2.
  - Reset release: first issue of RESET_PC at the first edge; o_valid=1 with o_pc=RESET_PC after the second edge.
  - Steady state, i_ready=1: one instruction per cycle, o_pc increments by 4 every cycle.
  - Stall release: after the release edge o_inst is the skid entry; the next edge delivers the following PC with no bubble and no duplicate.
- FSM view, encoded or derived:
  - BOOT: after reset, until the first issue.
  - RUN
  - STALL: blocked.
  - FLUSH: the cycle after a redirect.
  - Transitions: BOOT->RUN on first issue; RUN->STALL on blocked; STALL->RUN on i_ready; any state->FLUSH on i_redirect; FLUSH->RUN otherwise.
- Reset asserted mid-stall or mid-redirect discards everything and restarts from RESET_PC.
- Invariants:
  - No instruction is delivered twice or skipped.
  - o_pc sequence between redirects is strictly +4.

Test Plan:
- Reset release, i_ready=1, memory preloaded with word at address n = 32'h1000_0000+n → o_valid rises after the 2nd edge; o_pc 0,4,8,… with o_inst matching each address, one per cycle.
- i_ready low for 3 cycles while o_pc=8 → o_pc/o_inst hold at 8; o_imem_addr frozen; after i_ready rises, o_pc sequence is 8,12,16 with no gap or repeat.
- i_redirect pulse with i_redirect_pc=32'h0000_0043 while streaming → o_valid=0 for 2 cycles, then o_pc=32'h40, 32'h44, …; no wrong-path instruction appears.
- Redirect asserted in the same cycle as i_ready=0 with skid full → skid dropped; next valid o_pc = target.
- Redirect to 32'hFFFF_FFF8 → o_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulled low mid-stall (asynchronous, between edges) → outputs immediately o_valid=0, o_inst=32'h13, o_imem_addr=RESET_PC.
